fixed_to_float: RTL

FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

---
 rtl/fp_pkg.sv | 13 +
 rtl/fixed_to_float_if.sv | 35 +++
 rtl/fixed_lzc.sv | 26 ++
 rtl/fixed_to_float.sv | 119 +++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants for fixed-point to IEEE-754 single-precision conversion.
//   FP32_BIAS / FP32_EXP_W / FP32_MAN_W : binary32 field layout
//   DEFAULT_FIXED_W / DEFAULT_FRAC_W    : default Q2.20 input format
package fp_pkg;

   localparam int FP32_BIAS       = 127;
   localparam int FP32_EXP_W      = 8;
   localparam int FP32_MAN_W      = 23;

   localparam int DEFAULT_FIXED_W = 22;
   localparam int DEFAULT_FRAC_W  = 20;

endpackage

// File: rtl/fixed_to_float_if.sv
// Handshake bundle for fixed_to_float.
//   in_valid / in_ready / in_data    : fixed-point operand stream (upstream side)
//   out_valid / out_ready / out_data : binary32 result stream (downstream side)
// modport slave  : the converter
// modport master : the environment feeding and draining the converter
interface fixed_to_float_if #(
   parameter int FIXED_W = fp_pkg::DEFAULT_FIXED_W
) ();

   logic                      in_valid;
   logic                      in_ready;
   logic signed [FIXED_W-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [31:0]               out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

endinterface

// File: rtl/fixed_lzc.sv
// Leading-one detector.
//   value : unsigned operand
//   pos   : bit index of the most significant '1' in value (0 when value is 0)
//   zero  : value is all zeros
module fixed_lzc #(
   parameter int WIDTH = 22,
   parameter int POS_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] value,
   output logic [POS_W-1:0] pos,
   output logic             zero
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      pos  = '0;
      zero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            pos  = POS_W'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fixed_to_float.sv
// Signed fixed-point (FIXED_W bits, FRAC_W fractional) to IEEE-754 binary32.
// Three-stage pipeline, exact conversion (no rounding needed for FIXED_W-1 <= 24).
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears valids and out_data
//   bus   : fixed_to_float_if.slave
//           in_valid/in_ready/in_data    -> operand handshake
//           out_valid/out_ready/out_data -> result handshake
// The whole pipeline advances on enable = !out_valid || out_ready; in_ready = enable.
module fixed_to_float
   import fp_pkg::*;
#(
   parameter int FIXED_W = DEFAULT_FIXED_W,
   parameter int FRAC_W  = DEFAULT_FRAC_W
) (
   input  logic           clk,
   input  logic           reset,
   fixed_to_float_if.slave bus
);

   localparam int POS_W  = $clog2(FIXED_W);
   localparam int FRAC_N = FIXED_W - 1;   // bits that can sit below the leading one

   generate
      if (FIXED_W - 1 > 24 || FIXED_W < 2) begin : g_param_check
         $error("fixed_to_float: FIXED_W-1 must be <= 24 and FIXED_W >= 2 for exact conversion");
      end
   endgenerate

   function automatic logic [31:0] pack_fp32(
      input logic                  sign,
      input logic [FP32_EXP_W-1:0] exp,
      input logic [FP32_MAN_W-1:0] man,
      input logic                  zero
   );
      // A zero magnitude always packs to +0.0, never -0.0.
      if (zero) return 32'h0000_0000;
      return {sign, exp, man};
   endfunction

   logic enable;

   assign enable       = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = enable;

   // ---- Stage 1: sign / absolute value ----
   logic signed [FIXED_W-1:0] din;
   logic        [FIXED_W-1:0] mag_s1;
   logic                      vld_p0;
   logic                      sign_p0;
   logic        [FIXED_W-1:0] mag_p0;

   assign din = bus.in_data;
   // Unsigned FIXED_W-bit result holds the most negative input's magnitude exactly.
   assign mag_s1 = din[FIXED_W-1] ? FIXED_W'(-din) : FIXED_W'(din);

   // ---- Stage 2: leading-one detect + normalising shift ----
   logic [POS_W-1:0]  pos_s2;
   logic              zero_s2;
   logic [POS_W-1:0]  shamt_s2;
   logic [FRAC_N-1:0] frac_s2;
   logic              vld_p1;
   logic              sign_p1;
   logic [POS_W-1:0]  pos_p1;
   logic              zero_p1;
   logic [FRAC_N-1:0] frac_p1;

   fixed_lzc #(
      .WIDTH (FIXED_W),
      .POS_W (POS_W)
   ) u_lzc (
      .value (mag_p0),
      .pos   (pos_s2),
      .zero  (zero_s2)
   );

   assign shamt_s2 = POS_W'(FIXED_W - 1) - pos_s2;
   // Shifting the leading one to the MSB and dropping it leaves the bits below it left-aligned.
   assign frac_s2 = FRAC_N'(mag_p0 << shamt_s2);

   // ---- Stage 3: exponent / mantissa pack ----
   logic [FP32_EXP_W-1:0] exp_s3;
   logic [23:0]           man_wide_s3;
   logic [FP32_MAN_W-1:0] man_s3;

   assign exp_s3      = FP32_EXP_W'(int'(pos_p1) + FP32_BIAS - FRAC_W);
   // Align into a 24-bit field, then drop its LSB; with FRAC_N = 24 that LSB is always 0.
   assign man_wide_s3 = 24'(frac_p1) << (24 - FRAC_N);
   assign man_s3      = FP32_MAN_W'(man_wide_s3 >> 1);

   // Control path and the architecturally visible result register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0        <= 1'b0;
         vld_p1        <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= 32'h0000_0000;
      end else if (enable) begin
         vld_p0        <= bus.in_valid;
         vld_p1        <= vld_p0;
         bus.out_valid <= vld_p1;
         if (vld_p1) begin
            bus.out_data <= pack_fp32(sign_p1, exp_s3, man_s3, zero_p1);
         end
      end
   end

   // Datapath stage registers: no reset, they only matter alongside their valid bit.
   always_ff @(posedge clk) begin
      if (enable) begin
         sign_p0 <= din[FIXED_W-1];
         mag_p0  <= mag_s1;
         sign_p1 <= sign_p0;
         pos_p1  <= pos_s2;
         zero_p1 <= zero_s2;
         frac_p1 <= frac_s2;
      end
   end

endmodule
